relu_maxpool: RTL and testbench



---
 rtl/pool_pkg.sv | 33 +++
 rtl/pool_line_buf.sv | 36 +++
 rtl/relu_maxpool.sv | 167 ++++++++++++++++
 tb/tb_relu_maxpool.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared widths, FSM state type and small arithmetic helpers for the
// ReLU + 2x2 max-pool stage that follows the convolution block.
package pool_pkg;

    localparam int CONV_RESULT_BITS = 11;
    localparam int PIC_SIZE         = 28;
    localparam int FMAP_SIZE        = 24;
    localparam int POOL_SIZE        = FMAP_SIZE / 2;

    // Width of a ReLU'd (non-negative, sign-stripped) value.
    localparam int RES_W       = CONV_RESULT_BITS - 1;
    localparam int CONV_ADDR_W = $clog2(PIC_SIZE * PIC_SIZE);
    localparam int POOL_ADDR_W = $clog2(POOL_SIZE * POOL_SIZE);
    localparam int POS_W       = $clog2(FMAP_SIZE);
    localparam int LB_IDX_W    = $clog2(POOL_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Negative sums clamp to zero; otherwise the sign bit is dropped.
    function automatic logic [RES_W-1:0] relu(input logic [CONV_RESULT_BITS-1:0] x);
        return x[CONV_RESULT_BITS-1] ? '0 : x[RES_W-1:0];
    endfunction

    function automatic logic [RES_W-1:0] umax(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One row of horizontal pair maxima, written on even map rows and read
// back on the following odd row to finish each 2x2 window.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = POOL_SIZE,
    parameter int WIDTH = RES_W,
    parameter int IDX_W = LB_IDX_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write; contents need no reset since every entry is
    // rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read; out-of-range indices return zero.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over the convolution result
// stream. Position is tracked internally; the incoming address is only
// checked for ordering. One pooled value is emitted per window, registered
// in the cycle after the window's bottom-right sample.
module relu_maxpool
    import pool_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conv_result_valid,
    input  logic [CONV_RESULT_BITS-1:0] conv_result,
    input  logic [CONV_ADDR_W-1:0]      conv_result_addr,
    input  logic                        conv_finish,
    output logic                        pool_valid,
    output logic [RES_W-1:0]            pool_result,
    output logic [POOL_ADDR_W-1:0]      pool_addr,
    output logic                        pool_finish,
    output logic                        order_err,
    output state_e                      dbg_state
);

    // Handshake: conv_result_valid is a plain strobe with no ready; every
    // asserted cycle is consumed. pool_valid / pool_finish are one-cycle
    // pulses with no backpressure from downstream.

    localparam logic [POS_W-1:0] LAST_POS    = POS_W'(FMAP_SIZE - 1);
    localparam logic [POS_W-1:0] POOLED_EDGE = POS_W'(2 * POOL_SIZE);

    state_e                 state_q, state_d;
    logic [POS_W-1:0]       col_q, col_d;
    logic [POS_W-1:0]       row_q, row_d;
    logic [RES_W-1:0]       pair_q, pair_d;
    logic [POOL_ADDR_W-1:0] cnt_q, cnt_d;
    logic                   pool_valid_q, pool_valid_d;
    logic [RES_W-1:0]       pool_result_q, pool_result_d;
    logic [POOL_ADDR_W-1:0] pool_addr_q, pool_addr_d;
    logic                   pool_finish_q, pool_finish_d;
    logic                   order_err_q, order_err_d;

    logic                   lb_we;
    logic [LB_IDX_W-1:0]    lb_idx;
    logic [RES_W-1:0]       lb_rdata;
    logic [RES_W-1:0]       relu_val;
    logic [RES_W-1:0]       hmax;
    logic [CONV_ADDR_W-1:0] exp_addr;
    logic                   at_last;
    logic                   in_pool;

    assign relu_val = relu(conv_result);
    assign hmax     = umax(pair_q, relu_val);
    assign lb_idx   = LB_IDX_W'(col_q >> 1);
    assign exp_addr = CONV_ADDR_W'(row_q) * CONV_ADDR_W'(FMAP_SIZE) + CONV_ADDR_W'(col_q);
    assign at_last  = (col_q == LAST_POS) && (row_q == LAST_POS);
    // A trailing odd column/row would fall outside every window.
    assign in_pool  = (col_q < POOLED_EDGE) && (row_q < POOLED_EDGE);

    pool_line_buf u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (hmax),
        .raddr (lb_idx),
        .rdata (lb_rdata)
    );

    // Datapath, position tracking and FSM next-state.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        pair_d        = pair_q;
        cnt_d         = cnt_q;
        pool_valid_d  = 1'b0;
        pool_result_d = pool_result_q;
        pool_addr_d   = pool_addr_q;
        pool_finish_d = 1'b0;
        order_err_d   = order_err_q;
        lb_we         = 1'b0;

        if (conv_result_valid) begin
            if (conv_result_addr != exp_addr) begin
                order_err_d = 1'b1;
            end
            if (col_q == LAST_POS) begin
                col_d = '0;
                row_d = (row_q == LAST_POS) ? '0 : row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
            if (!col_q[0]) begin
                pair_d = relu_val;
            end else if (in_pool) begin
                if (!row_q[0]) begin
                    lb_we = 1'b1;
                end else begin
                    pool_valid_d  = 1'b1;
                    pool_result_d = umax(lb_rdata, hmax);
                    pool_addr_d   = cnt_q;
                    cnt_d         = cnt_q + POOL_ADDR_W'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (conv_result_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (conv_result_valid && at_last) begin
                    // Counters have wrapped to (0,0) on their own.
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (conv_finish) begin
                    // Partial map: abandon position, flag the short map.
                    state_d     = DONE;
                    col_d       = '0;
                    row_d       = '0;
                    cnt_d       = '0;
                    order_err_d = 1'b1;
                end
            end
            DONE: begin
                pool_finish_d = 1'b1;
                pool_addr_d   = '0;
                state_d       = conv_result_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            pair_q        <= '0;
            cnt_q         <= '0;
            pool_valid_q  <= 1'b0;
            pool_result_q <= '0;
            pool_addr_q   <= '0;
            pool_finish_q <= 1'b0;
            order_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pair_q        <= pair_d;
            cnt_q         <= cnt_d;
            pool_valid_q  <= pool_valid_d;
            pool_result_q <= pool_result_d;
            pool_addr_q   <= pool_addr_d;
            pool_finish_q <= pool_finish_d;
            order_err_q   <= order_err_d;
        end
    end

    assign pool_valid  = pool_valid_q;
    assign pool_result = pool_result_q;
    assign pool_addr   = pool_addr_q;
    assign pool_finish = pool_finish_q;
    assign order_err   = order_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: reset, constant, ReLU, ramp, ordering
// error and mid-map finish/reset scenarios against a window-max model.
module tb_relu_maxpool;
    import pool_pkg::*;

    logic                        clk;
    logic                        rst;
    logic                        conv_result_valid;
    logic [CONV_RESULT_BITS-1:0] conv_result;
    logic [CONV_ADDR_W-1:0]      conv_result_addr;
    logic                        conv_finish;
    logic                        pool_valid;
    logic [RES_W-1:0]            pool_result;
    logic [POOL_ADDR_W-1:0]      pool_addr;
    logic                        pool_finish;
    logic                        order_err;
    state_e                      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int n_finish = 0;
    int last_valid_cyc = 0;
    int finish_cyc = 0;
    int cyc = 0;
    int vals [FMAP_SIZE*FMAP_SIZE];
    logic [17:0] exp_q [$];

    relu_maxpool dut (
        .clk               (clk),
        .rst               (rst),
        .conv_result_valid (conv_result_valid),
        .conv_result       (conv_result),
        .conv_result_addr  (conv_result_addr),
        .conv_finish       (conv_finish),
        .pool_valid        (pool_valid),
        .pool_result       (pool_result),
        .pool_addr         (pool_addr),
        .pool_finish       (pool_finish),
        .order_err         (order_err),
        .dbg_state         (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pooled output must match the head of exp_q.
    always @(negedge clk) begin
        logic [17:0] got;
        logic [17:0] exp_v;
        if (pool_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            got = {pool_addr, pool_result};
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_pool_valid got addr=%0d res=%0d exp=none", pool_addr, pool_result);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                assert (got === exp_v) else begin
                    n_errors++;
                    $error("FAIL pool_out got addr=%0d res=%0d exp addr=%0d res=%0d",
                           got[17:10], got[9:0], exp_v[17:10], exp_v[9:0]);
                end
            end
        end
        if (pool_finish === 1'b1) begin
            n_finish++;
            finish_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        assert (got === exp_v) else begin
            n_errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        conv_result_valid = 1'b0;
        conv_result       = '0;
        conv_result_addr  = '0;
        conv_finish       = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // mode 0: constant c; mode 1: ReLU window pattern; mode 2: addr%500 ramp
    task automatic fill(input int mode, input int c);
        for (int i = 0; i < FMAP_SIZE*FMAP_SIZE; i++) begin
            case (mode)
                0: vals[i] = c;
                1: vals[i] = -4;
                default: vals[i] = i % 500;
            endcase
        end
        if (mode == 1) begin
            vals[0] = -3; vals[1] = 7; vals[24] = -1; vals[25] = 2;
        end
    endtask

    // Push expected outputs for windows whose bottom-right index < n.
    task automatic push_expected(input int n);
        int m;
        int v;
        for (int pr = 0; pr < POOL_SIZE; pr++) begin
            for (int pc = 0; pc < POOL_SIZE; pc++) begin
                if ((2*pr+1)*FMAP_SIZE + 2*pc + 1 < n) begin
                    m = 0;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            v = vals[(2*pr+dr)*FMAP_SIZE + 2*pc + dc];
                            if (v > m) m = v;
                        end
                    end
                    exp_q.push_back({8'(pr*POOL_SIZE + pc), 10'(m)});
                end
            end
        end
    endtask

    task automatic send_map(input int n, input int skip_slot, input bit fin_last);
        for (int i = 0; i < n; i++) begin
            conv_result_valid = 1'b1;
            conv_result       = CONV_RESULT_BITS'(vals[i]);
            conv_result_addr  = CONV_ADDR_W'((i == skip_slot) ? i + 1 : i);
            conv_finish       = fin_last && (i == n - 1);
            if (i == skip_slot) check("order_err_before_skip", order_err, 0);
            tick();
            if (i == skip_slot) check("order_err_after_skip", order_err, 1);
        end
        idle_inputs();
    endtask

    task automatic finish_map(input string tag, input int v0, input int f0,
                              input int exp_cnt, input bit chk_timing);
        int k;
        k = 0;
        while (n_finish == f0 && k < 20) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check({tag, "_finish_once"}, n_finish - f0, 1);
        check({tag, "_count"}, n_valid - v0, exp_cnt);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (chk_timing) check({tag, "_finish_timing"}, finish_cyc, last_valid_cyc + 1);
        check({tag, "_state_idle"}, dbg_state, IDLE);
    endtask

    initial begin
        int v0;
        int f0;
        idle_inputs();
        rst = 1'b1;

        // 1. reset held 3 cycles with valid traffic
        for (int i = 0; i < 3; i++) begin
            conv_result_valid = 1'b1;
            conv_result       = CONV_RESULT_BITS'(5);
            conv_result_addr  = CONV_ADDR_W'(i);
            tick();
            check("reset_outputs", {pool_valid, pool_result, pool_addr, pool_finish, order_err}, 0);
            check("reset_state", dbg_state, IDLE);
        end
        idle_inputs();
        rst = 1'b0;
        tick();

        // 2. constant stream, conv_finish together with last sample
        fill(0, 5);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, -1, 1'b1);
        finish_map("const", v0, f0, 144, 1'b1);
        check("const_order_err", order_err, 0);

        // 3. ReLU window, map ends by counters alone
        fill(1, 0);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, -1, 1'b0);
        finish_map("relu", v0, f0, 144, 1'b1);

        // 4. ramp addr%500, includes the 499 window
        fill(2, 0);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, -1, 1'b0);
        finish_map("ramp", v0, f0, 144, 1'b1);
        check("ramp_order_err", order_err, 0);

        // 5. address 30 replaced by 31
        fill(0, 9);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, 30, 1'b1);
        finish_map("order", v0, f0, 144, 1'b1);
        check("order_err_sticky", order_err, 1);

        // 6a. early conv_finish after 100 samples, then a full map
        apply_reset();
        check("reset_clears_order_err", order_err, 0);
        fill(0, 3);
        push_expected(100);
        v0 = n_valid; f0 = n_finish;
        send_map(100, -1, 1'b0);
        conv_finish = 1'b1;
        tick();
        conv_finish = 1'b0;
        finish_map("early", v0, f0, 24, 1'b0);
        check("early_order_err", order_err, 1);
        fill(0, 6);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, -1, 1'b1);
        finish_map("after_early", v0, f0, 144, 1'b1);

        // 6b. reset after 300 samples, then a clean map
        apply_reset();
        fill(0, 7);
        push_expected(300);
        v0 = n_valid; f0 = n_finish;
        send_map(300, -1, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_count", n_valid - v0, 72);
        check("midrst_no_finish", n_finish - f0, 0);
        check("midrst_queue_empty", exp_q.size(), 0);
        fill(0, 5);
        push_expected(576);
        v0 = n_valid; f0 = n_finish;
        send_map(576, -1, 1'b1);
        finish_map("clean", v0, f0, 144, 1'b1);
        check("clean_order_err", order_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
